// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite protocol constants shared by AHB masters and slaves in this
// codebase: HTRANS, HBURST, HSIZE and HRESP encodings.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb3lite_burst_master.sv
// AHB3-Lite burst master: turns one command (address, direction, size,
// beat count) into a pipelined INCR/SINGLE burst, streaming write data in
// and read data out. Bursts are restarted with NONSEQ at 1 KB boundaries.
// Optional: define AHB3LITE_BURST_MASTER_FIXED_BURST_EN to issue
// INCR4/INCR8/INCR16 for 4/8/16-beat commands that stay inside 1 KB.
//
// Handshakes: a transfer on cmd_* or wdata* happens in a cycle where both
// valid and ready are high; a source that raises valid must hold it (and
// its payload) stable until that cycle. Write beats rely on this: a beat is
// shown as NONSEQ/SEQ only while wdata_valid is high, and the word is taken
// when that address phase completes.
module ahb3lite_burst_master
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MAX_BEATS  = 16,
  localparam int BW        = $clog2(MAX_BEATS + 1)
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [BW-1:0]         cmd_beats,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [HDATA_SIZE-1:0] wdata,
  output logic                  rdata_valid,
  output logic [HDATA_SIZE-1:0] rdata,
  output logic                  done,
  output logic                  err,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic [1:0]            fsm_state
);

  // ADDR: address phases still to issue; DATA: only the last data phase
  // outstanding; ERR: second cycle of an error response (or illegal command).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [2:0] MAX_SIZE = 3'($clog2(HDATA_SIZE / 8));

  state_t                state_q, state_d;
  logic [HADDR_SIZE-1:0] haddr_q;
  logic [HDATA_SIZE-1:0] hwdata_q;
  logic                  hwrite_q;
  logic [2:0]            hsize_q;
  logic [2:0]            hburst_q;
  logic [1:0]            htrans_q;
  logic [BW-1:0]         beats_left_q;
  logic                  dphase_q;

  logic                  cmd_fire;
  logic                  cmd_illegal;
  logic [2:0]            first_burst;
  logic [HADDR_SIZE-1:0] next_addr;
  logic                  crosses_1k;
  logic                  addr_phase;
  logic                  addr_xfer;
  logic                  last_addr;
  logic                  data_err;

  assign cmd_fire    = cmd_valid & cmd_ready;
  assign cmd_illegal = (cmd_size > MAX_SIZE) || (cmd_beats == '0) ||
                       (int'(cmd_beats) > MAX_BEATS);
  assign next_addr   = haddr_q + (HADDR_SIZE'(1) << hsize_q);
  assign crosses_1k  = (next_addr >> 10) != (haddr_q >> 10);
  assign addr_phase  = (state_q == ST_ADDR) && htrans_q[1] && (!hwrite_q || wdata_valid);
  assign addr_xfer   = addr_phase && HREADY;
  assign last_addr   = (beats_left_q == BW'(1));
  assign data_err    = dphase_q && !HREADY && (HRESP == HRESP_ERROR);

`ifdef AHB3LITE_BURST_MASTER_FIXED_BURST_EN
  logic [HADDR_SIZE-1:0] cmd_last_addr;
  logic                  cmd_span_cross;
  assign cmd_last_addr  = cmd_addr + (HADDR_SIZE'(cmd_beats - BW'(1)) << cmd_size);
  assign cmd_span_cross = (cmd_last_addr >> 10) != (cmd_addr >> 10);
`endif

  // Burst type for the first beat of an accepted command.
  always_comb begin
    first_burst = (cmd_beats == BW'(1)) ? HBURST_SINGLE : HBURST_INCR;
`ifdef AHB3LITE_BURST_MASTER_FIXED_BURST_EN
    if (!cmd_span_cross) begin
      if (int'(cmd_beats) == 4)       first_burst = HBURST_INCR4;
      else if (int'(cmd_beats) == 8)  first_burst = HBURST_INCR8;
      else if (int'(cmd_beats) == 16) first_burst = HBURST_INCR16;
    end
`endif
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and command/status outputs.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_fire) state_d = cmd_illegal ? ST_ERR : ST_ADDR;
      end
      ST_ADDR: begin
        if (data_err)                    state_d = ST_ERR;
        else if (addr_xfer && last_addr) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (data_err) state_d = ST_ERR;
        else if (HREADY) begin
          done    = 1'b1;
          err     = (HRESP == HRESP_ERROR);
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write beats without data show IDLE (burst start) or BUSY (mid-burst).
  always_comb begin
    HTRANS = htrans_q;
    if ((state_q == ST_ADDR) && hwrite_q && !wdata_valid) begin
      if (htrans_q == HTRANS_NONSEQ)   HTRANS = HTRANS_IDLE;
      else if (htrans_q == HTRANS_SEQ) HTRANS = HTRANS_BUSY;
    end
  end

  // Address/control pipeline: advances only when the bus accepts a phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_q      <= '0;
      hwdata_q     <= '0;
      hwrite_q     <= 1'b0;
      hsize_q      <= 3'b000;
      hburst_q     <= HBURST_SINGLE;
      htrans_q     <= HTRANS_IDLE;
      beats_left_q <= '0;
      dphase_q     <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      dphase_q <= 1'b0;
      if (cmd_fire && !cmd_illegal) begin
        haddr_q      <= cmd_addr;
        hwrite_q     <= cmd_write;
        hsize_q      <= cmd_size;
        hburst_q     <= first_burst;
        htrans_q     <= HTRANS_NONSEQ;
        beats_left_q <= cmd_beats;
      end
    end else if ((state_q == ST_ADDR) || (state_q == ST_DATA)) begin
      if (data_err) begin
        htrans_q <= HTRANS_IDLE;
        dphase_q <= 1'b0;
      end else begin
        if (HREADY) dphase_q <= addr_xfer;
        if (addr_xfer) begin
          beats_left_q <= beats_left_q - BW'(1);
          if (hwrite_q) hwdata_q <= wdata;
          if (last_addr) begin
            htrans_q <= HTRANS_IDLE;
          end else begin
            haddr_q  <= next_addr;
            htrans_q <= crosses_1k ? HTRANS_NONSEQ : HTRANS_SEQ;
            if (crosses_1k) hburst_q <= HBURST_INCR;
          end
        end
      end
    end else begin
      htrans_q <= HTRANS_IDLE;
      dphase_q <= 1'b0;
    end
  end

  assign wdata_ready = addr_xfer && hwrite_q;
  assign rdata_valid = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && dphase_q &&
                       !hwrite_q && HREADY && (HRESP == HRESP_OKAY);
  assign rdata       = HRDATA;
  assign HADDR       = haddr_q;
  assign HWDATA      = hwdata_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = hburst_q;
  assign HPROT       = 4'b0011;
  assign HMASTLOCK   = 1'b0;
  assign fsm_state   = state_q;

endmodule
